// File: rtl/rom_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rom_fetch_ctrl
// Purpose  : Instruction-fetch sequencer for a combinational 32-bit ROM.
//            Owns the PC, drives the ROM byte address, and captures each
//            returned word with its PC into a small in-order queue that is
//            handed to decode over a valid/ready handshake. Handles
//            redirects, downstream backpressure, and halts when it fetches an
//            all-zero word.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start               - pulse, begins fetching at RESET_PC
//            rom_addr / rom_data - ROM byte address out, read data in
//            redirect_valid/_pc  - taken branch/jump and its target
//            out_valid/_ready    - decode handshake
//            out_instr / out_pc  - queue head instruction and its PC
//            halted              - high while in the HALT state
//            fetch_count         - instructions enqueued since start
// Revision : 1.0 - initial release
// ============================================================================
module rom_fetch_ctrl #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_HALT = 2'd2;

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [15:0]        r_fetch_count;

  logic [DATA_W-1:0]  r_instr_q [DEPTH];
  logic [ADDR_W-1:0]  r_pc_q    [DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;

  logic              w_pop;
  logic              w_space;
  logic              w_flush;
  logic              w_run_slot;
  logic              w_rom_zero;
  logic              w_push;
  logic              w_halt;
  logic [ADDR_W-1:0] w_target;
  logic [1:0]        w_unused_redirect_lsbs;

  // Targets are word aligned; the low address bits carry no information.
  assign w_target               = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_unused_redirect_lsbs = redirect_pc[1:0];

  // A redirect flushes the queue in RUN and HALT; in IDLE it is ignored.
  assign w_flush    = redirect_valid & (r_state != c_IDLE);
  assign w_pop      = (r_count != '0) & out_ready;
  // A full queue can still accept when the head leaves in the same cycle.
  assign w_space    = (r_count < c_DEPTH) | w_pop;
  assign w_run_slot = (r_state == c_RUN) & ~redirect_valid & w_space;
  assign w_rom_zero = (rom_data == '0);
  assign w_push     = w_run_slot & ~w_rom_zero;
  assign w_halt     = w_run_slot & w_rom_zero;

  // --------------------------------------------------------------------------
  // Sequencer: state, PC and fetch counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_IDLE;
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state       <= c_RUN;
            r_pc          <= RESET_PC;
            r_fetch_count <= '0;
          end
        end
        c_RUN: begin
          if (redirect_valid) begin
            r_pc <= w_target;
          end else if (w_push) begin
            r_pc          <= r_pc + ADDR_W'(4);
            r_fetch_count <= r_fetch_count + 16'd1;
          end else if (w_halt) begin
            r_state <= c_HALT;
          end
          // With no space the PC holds and the ROM simply re-reads it.
        end
        c_HALT: begin
          if (redirect_valid) begin
            r_state <= c_RUN;
            r_pc    <= w_target;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Fetch queue: circular buffer with a separate occupancy counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr_q[i] <= '0;
        r_pc_q[i]    <= '0;
      end
    end else if (w_flush) begin
      // Flush takes priority over a concurrent pop: the head is dropped,
      // not handed to decode.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_instr_q[r_wptr] <= rom_data;
        r_pc_q[r_wptr]    <= r_pc;
        r_wptr            <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rom_addr    = r_pc;
  assign out_valid   = (r_count != '0);
  assign out_instr   = r_instr_q[r_rptr];
  assign out_pc      = r_pc_q[r_rptr];
  assign halted      = (r_state == c_HALT);
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_rom_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_fetch_ctrl
// Purpose  : Self-checking bench for rom_fetch_ctrl. A bench-side ROM feeds
//            the DUT; expected {pc, instr} pairs go into a scoreboard queue
//            when the fetch is set up and are popped on each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [4:0]  out_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] rom [8];
  assign rom_data = rom[rom_addr[4:2]];

  typedef struct packed {
    logic [4:0]  pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks;
  int   n_fail;
  int   got;

  rom_fetch_ctrl #(
    .ADDR_W   (5),
    .DATA_W   (32),
    .DEPTH    (2),
    .RESET_PC (5'd0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_rom();
    rom[0] = 32'h00300413; rom[1] = 32'h00100493;
    rom[2] = 32'h00200513; rom[3] = 32'h00a00593;
    rom[4] = 32'h00947333; rom[5] = 32'h40b50633;
    rom[6] = 32'h00c586b3; rom[7] = 32'h00d60733;
  endtask

  task automatic push_exp(input logic [4:0] pc);
    sb.push_back('{pc: pc, instr: rom[pc[4:2]]});
  endtask

  // Asserts reset across one negedge and releases on the next.
  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulses start; returns at the negedge just after the start edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    n_checks++; if (out_pc !== 5'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_checks++; if (fetch_count !== 16'h0) begin n_fail++; $display("FAIL reset_fcount: got %0d want 0", fetch_count); end
    n_checks++; if (rom_addr !== 5'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", rom_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 5'h10;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (rom_addr !== 5'h0) begin n_fail++; $display("FAIL idle_addr: got %h want 0", rom_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) push_exp(5'(4 * k));
    push_exp(5'd0);
    got = 0;
    do_start();
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      if (c > 0) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid: cycle %0d got %b want 1", c, out_valid); end
      end
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        n_checks++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          n_fail++; $display("FAIL stream_hs: got pc %h instr %h want pc %h instr %h", out_pc, out_instr, e.pc, e.instr);
        end
        got++;
        if (got == 8) begin
          n_checks++; if (fetch_count !== 16'd8) begin n_fail++; $display("FAIL stream_fcount: got %0d want 8", fetch_count); end
        end
      end
      @(negedge clk);
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL stream_timeout: %0d left want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    do_reset();
    do_start();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 5'h0 || out_instr !== rom[0]) begin
        n_fail++; $display("FAIL bp_stable: cycle %0d got v %b pc %h instr %h want v 1 pc 0 instr %h", i, out_valid, out_pc, out_instr, rom[0]);
      end
      if (i >= 2) begin
        n_checks++; if (rom_addr !== 5'h08) begin n_fail++; $display("FAIL bp_addr: cycle %0d got %h want 08", i, rom_addr); end
      end
    end
    for (int k = 0; k < 5; k++) push_exp(5'(4 * k));
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        n_checks++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          n_fail++; $display("FAIL bp_hs: got pc %h instr %h want pc %h instr %h", out_pc, out_instr, e.pc, e.instr);
        end
      end
      @(negedge clk);
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL bp_timeout: %0d left want 0", sb.size()); end
  endtask

  task automatic test_redirect();
    do_reset();
    do_start();
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;      // one pop: queue goes from {0,4} to {4,8}
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_pc !== 5'h04) begin n_fail++; $display("FAIL redir_pre_head: got %h want 04", out_pc); end
    redirect_valid = 1'b1; redirect_pc = 5'h13;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %b want 0", out_valid); end
    n_checks++; if (rom_addr !== 5'h10) begin n_fail++; $display("FAIL redir_addr: got %h want 10", rom_addr); end
    n_checks++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL redir_fcount: got %0d want 3", fetch_count); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 5'h10 || out_instr !== 32'h00947333) begin
      n_fail++; $display("FAIL redir_first: got v %b pc %h instr %h want v 1 pc 10 instr 00947333", out_valid, out_pc, out_instr);
    end
    push_exp(5'h10); push_exp(5'h14);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        n_checks++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          n_fail++; $display("FAIL redir_hs: got pc %h instr %h want pc %h instr %h", out_pc, out_instr, e.pc, e.instr);
        end
      end
      @(negedge clk);
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL redir_timeout: %0d left want 0", sb.size()); end
  endtask

  task automatic test_halt();
    do_reset();
    rom[3] = 32'h0;
    out_ready = 1'b1;
    push_exp(5'h00); push_exp(5'h04); push_exp(5'h08);
    do_start();
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        n_checks++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          n_fail++; $display("FAIL halt_hs: got pc %h instr %h want pc %h instr %h", out_pc, out_instr, e.pc, e.instr);
        end
      end
      @(negedge clk);
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL halt_timeout: %0d left want 0", sb.size()); end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", halted); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drain: got %b want 0", out_valid); end
    start = 1'b1;          // ignored while halted
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold: got %b want 1", halted); end
    n_checks++; if (rom_addr !== 5'h0c) begin n_fail++; $display("FAIL halt_addr: got %h want 0c", rom_addr); end
    n_checks++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL halt_fcount: got %0d want 3", fetch_count); end
    redirect_valid = 1'b1; redirect_pc = 5'h00;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_resume: got %b want 0", halted); end
    n_checks++; if (rom_addr !== 5'h00) begin n_fail++; $display("FAIL halt_resume_addr: got %h want 00", rom_addr); end
    push_exp(5'h00); push_exp(5'h04); push_exp(5'h08);
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        n_checks++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          n_fail++; $display("FAIL halt_re_hs: got pc %h instr %h want pc %h instr %h", out_pc, out_instr, e.pc, e.instr);
        end
      end
      @(negedge clk);
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL halt_re_timeout: %0d left want 0", sb.size()); end
    load_rom();
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_start();
    repeat (3) @(negedge clk);
    n_checks++;
    if (rom_addr !== 5'h08 || out_pc !== 5'h00 || fetch_count !== 16'd2) begin
      n_fail++; $display("FAIL b2b_full: got addr %h pc %h fc %0d want 08 00 2", rom_addr, out_pc, fetch_count);
    end
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 5'h0e;
    @(negedge clk);
    out_ready = 1'b0; redirect_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_flush: got %b want 0", out_valid); end
    n_checks++; if (rom_addr !== 5'h0c) begin n_fail++; $display("FAIL b2b_addr: got %h want 0c", rom_addr); end
    n_checks++; if (fetch_count !== 16'd2) begin n_fail++; $display("FAIL b2b_fcount: got %0d want 2", fetch_count); end
    push_exp(5'h0c); push_exp(5'h10);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        n_checks++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          n_fail++; $display("FAIL b2b_hs: got pc %h instr %h want pc %h instr %h", out_pc, out_instr, e.pc, e.instr);
        end
      end
      @(negedge clk);
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_timeout: %0d left want 0", sb.size()); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    do_start();
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
    out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL mid_halted: got %b want 0", halted); end
    n_checks++; if (fetch_count !== 16'h0) begin n_fail++; $display("FAIL mid_fcount: got %0d want 0", fetch_count); end
    n_checks++; if (rom_addr !== 5'h0) begin n_fail++; $display("FAIL mid_addr: got %h want 0", rom_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || rom_addr !== 5'h0 || fetch_count !== 16'h0) begin
      n_fail++; $display("FAIL mid_nofetch: got v %b addr %h fc %0d want 0 0 0", out_valid, rom_addr, fetch_count);
    end
    push_exp(5'h00); push_exp(5'h04);
    do_start();
    for (int c = 0; c < 10 && sb.size() != 0; c++) begin
      if (out_valid && out_ready) begin
        e = sb.pop_front();
        n_checks++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          n_fail++; $display("FAIL mid_hs: got pc %h instr %h want pc %h instr %h", out_pc, out_instr, e.pc, e.instr);
        end
      end
      @(negedge clk);
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL mid_timeout: %0d left want 0", sb.size()); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    load_rom();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
